fifo_wc_sync: RTL and testbench

FIFO_WC_SYNC -- requirements
Module: fifo_wc_sync

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_wc_bank.sv | 39 +++
 rtl/fifo_wc_sync.sv | 108 ++++++++++
 tb/tb_fifo_wc_sync.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFO: log2 sizing, pointer width and
// the legal read/write ratio set.
package fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointers carry one extra bit so full and empty stay distinguishable.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit ratio_legal(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4);
    endfunction

endpackage

// File: rtl/fifo_wc_bank.sv
// One storage bank: simple dual-port RAM with synchronous write and a
// registered synchronous read that holds its value between reads.
module fifo_wc_bank #(
    parameter int DW = 64,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int ROWS = 2 ** AW;

    logic [DW-1:0] mem_q [ROWS];
    logic [DW-1:0] rdata_q;

    // Array storage is intentionally left uninitialised on reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; only an accepted read may change it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_wc_sync.sv
// Synchronous FIFO writing WR_DW-bit words and reading RATIO of them at once,
// packed little-endian. Pointers count write words; storage is RATIO banks.
module fifo_wc_sync
    import fifo_pkg::*;
#(
    parameter int WR_DW    = 64,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = RATIO
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wen,
    input  logic [WR_DW-1:0]            wdata,
    input  logic                        ren,
    output logic [WR_DW*RATIO-1:0]      rdata,
    output logic                        empty,
    output logic                        almost_empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [ptr_width(DEPTH)-1:0] wr_count,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = clog2(DEPTH);
    localparam int SEL_W  = clog2(RATIO);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("fifo_wc_sync: RATIO must be 1, 2 or 4");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc_s, rd_acc_s;

    assign wr_count     = wr_ptr_q - rd_ptr_q;
    assign full         = (wr_count == PTR_W'(DEPTH));
    assign empty        = (wr_count <  PTR_W'(RATIO));
    assign almost_full  = (wr_count >= PTR_W'(AF_LEVEL));
    assign almost_empty = (wr_count <= PTR_W'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc_s = wen && !full;
    assign rd_acc_s = ren && !empty;

    // Next-state for pointers and error pulses; write and read act independently.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = wen && full;
        underflow_d = ren && empty;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(32'd1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(RATIO);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Word k of a read row lives in bank k, so bank k feeds rdata slice k.
    for (genvar b = 0; b < RATIO; b++) begin : g_bank
        logic bank_we_s;
        if (RATIO == 1) begin : g_one
            assign bank_we_s = wr_acc_s;
        end else begin : g_sel
            assign bank_we_s = wr_acc_s && (wr_ptr_q[SEL_W-1:0] == SEL_W'(b));
        end

        fifo_wc_bank #(
            .DW (WR_DW),
            .AW (ADDR_W - SEL_W)
        ) u_bank (
            .clk_i   (clk),
            .rst_n_i (rstn),
            .we_i    (bank_we_s),
            .waddr_i (wr_ptr_q[ADDR_W-1:SEL_W]),
            .wdata_i (wdata),
            .re_i    (rd_acc_s),
            .raddr_i (rd_ptr_q[ADDR_W-1:SEL_W]),
            .rdata_o (rdata[b*WR_DW +: WR_DW])
        );
    end

endmodule

// File: tb/tb_fifo_wc_sync.sv
// Directed bench for fifo_wc_sync (64-bit writes, 2:1 ratio, depth 16) with a
// queue-based reference model compared on every falling clock edge.
module tb_fifo_wc_sync;
    localparam int WR_DW    = 64;
    localparam int RATIO    = 2;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic         clk   = 1'b0;
    logic         rstn  = 1'b0;
    logic         wen   = 1'b0;
    logic         ren   = 1'b0;
    logic [63:0]  wdata = 64'd0;
    logic [127:0] rdata;
    logic         empty, almost_empty, full, almost_full, overflow, underflow;
    logic [4:0]   wr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0]  mq [$];
    logic [127:0] m_rdata = 128'd0;
    logic         m_ovf   = 1'b0;
    logic         m_unf   = 1'b0;

    fifo_wc_sync #(
        .WR_DW    (WR_DW),
        .RATIO    (RATIO),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wen          (wen),
        .wdata        (wdata),
        .ren          (ren),
        .rdata        (rdata),
        .empty        (empty),
        .almost_empty (almost_empty),
        .full         (full),
        .almost_full  (almost_full),
        .wr_count     (wr_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_data(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: an ordered queue of write words.
    always @(posedge clk or negedge rstn) begin : model
        int  n;
        bit  do_w, do_r;
        if (!rstn) begin
            mq.delete();
            m_rdata = 128'd0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            n     = mq.size();
            do_w  = wen && (n < DEPTH);
            do_r  = ren && (n >= RATIO);
            m_ovf = wen && (n == DEPTH);
            m_unf = ren && (n < RATIO);
            if (do_r) begin
                for (int k = 0; k < RATIO; k++) begin
                    m_rdata[k*WR_DW +: WR_DW] = mq.pop_front();
                end
            end
            if (do_w) begin
                mq.push_back(wdata);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        int n;
        n = mq.size();
        check_data("cyc_rdata", rdata, m_rdata);
        check_cnt("cyc_wr_count", wr_count, 5'(n));
        check_bit("cyc_empty", empty, n < RATIO);
        check_bit("cyc_almost_empty", almost_empty, n <= AE_LEVEL);
        check_bit("cyc_full", full, n == DEPTH);
        check_bit("cyc_almost_full", almost_full, n >= AF_LEVEL);
        check_bit("cyc_overflow", overflow, m_ovf);
        check_bit("cyc_underflow", underflow, m_unf);
    end

    task automatic tick(input logic w, input logic [63:0] d, input logic r);
        wen   = w;
        wdata = d;
        ren   = r;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check_bit("rst_empty", empty, 1'b1);
        check_bit("rst_ae", almost_empty, 1'b1);
        check_bit("rst_full", full, 1'b0);
        check_bit("rst_af", almost_full, 1'b0);
        check_cnt("rst_count", wr_count, 5'd0);
        check_data("rst_rdata", rdata, 128'd0);

        tick(1'b1, 64'h1111_1111_1111_1111, 1'b0);
        check_bit("one_word_empty", empty, 1'b1);
        tick(1'b1, 64'h2222_2222_2222_2222, 1'b0);
        check_bit("two_word_empty", empty, 1'b0);
        check_cnt("two_word_count", wr_count, 5'd2);
        tick(1'b0, 64'd0, 1'b1);
        check_data("pack_order", rdata, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check_bit("after_read_empty", empty, 1'b1);

        tick(1'b1, 64'h3333_3333_3333_3333, 1'b0);
        check_cnt("partial_count", wr_count, 5'd1);
        check_bit("partial_empty", empty, 1'b1);
        check_bit("partial_ae", almost_empty, 1'b1);
        tick(1'b0, 64'd0, 1'b1);
        check_bit("underflow_pulse", underflow, 1'b1);
        check_data("underflow_hold", rdata, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        tick(1'b0, 64'd0, 1'b0);
        check_bit("underflow_clear", underflow, 1'b0);

        for (int i = 0; i < 15; i++) tick(1'b1, {32'hA000_0000, 32'(i)}, 1'b0);
        check_bit("fill_full", full, 1'b1);
        check_bit("fill_af", almost_full, 1'b1);
        check_cnt("fill_count", wr_count, 5'd16);
        tick(1'b1, 64'hDEAD_BEEF_0000_0017, 1'b1);
        check_bit("overflow_pulse", overflow, 1'b1);
        check_cnt("overflow_count", wr_count, 5'd14);
        check_data("overflow_rdata", rdata, {64'hA000_0000_0000_0000, 64'h3333_3333_3333_3333});
        tick(1'b0, 64'd0, 1'b0);
        check_bit("overflow_clear", overflow, 1'b0);

        repeat (3) tick(1'b0, 64'd0, 1'b1);
        check_cnt("drain_to_8", wr_count, 5'd8);
        tick(1'b1, 64'hB000_0000_0000_0000, 1'b1);
        check_cnt("simul_rw_count", wr_count, 5'd7);

        for (int i = 0; i < 24; i++) tick(1'b1, {32'hC000_0000, 32'(i)}, (i % 2) == 1);
        check_cnt("wrap_count", wr_count, 5'd7);
        for (int k = 0; k < 20; k++) begin
            if (mq.size() >= RATIO) tick(1'b0, 64'd0, 1'b1);
        end
        check_cnt("wrap_drain_count", wr_count, 5'd1);
        check_data("wrap_last_rdata", rdata, {64'hC000_0000_0000_0016, 64'hC000_0000_0000_0015});

        for (int i = 0; i < 9; i++) tick(1'b1, {32'hD000_0000, 32'(i)}, 1'b0);
        check_cnt("pre_reset_count", wr_count, 5'd10);
        #2 rstn = 1'b0;
        #1;
        check_cnt("async_rst_count", wr_count, 5'd0);
        check_bit("async_rst_empty", empty, 1'b1);
        check_bit("async_rst_full", full, 1'b0);
        check_data("async_rst_rdata", rdata, 128'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        tick(1'b1, 64'hE111_0000_0000_0001, 1'b0);
        tick(1'b1, 64'hE222_0000_0000_0002, 1'b0);
        tick(1'b0, 64'd0, 1'b1);
        check_data("resume_rdata", rdata, {64'hE222_0000_0000_0002, 64'hE111_0000_0000_0001});
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
